// File: rtl/vga_rect_writer.sv
// -----------------------------------------------------------------------------
// vga_rect_writer
//
// Bus-initiator drawing engine for the VGA peripheral. A rectangle command
// (two corners) is normalised and clamped to the frame buffer. The engine then
// requests the shared 8-bit bus and writes the Y register once per row and the
// X register once per pixel, so the VGA block sets every pixel in the rectangle.
//
// Optional feature macro: VGA_RECT_COLOUR_EN
//   defined   -> COLOUR port exists; the colour register (base address) is
//                written once before the first row.
//   undefined -> no COLOUR port; the colour register is left untouched.
//
// Timing model: START is sampled on a rising edge. BUSY and BUS_REQ appear
// after the next edge. The first write appears in the cycle in which
// BUS_GNT is first sampled high while the request is pending. With the grant
// held high, that write therefore follows the REQ cycle directly. Each bus
// output is registered, and its value reflects the action taken at the edge
// that produced it.
// -----------------------------------------------------------------------------
module vga_rect_writer #(
    parameter logic [7:0] VGA_BASE_ADDR = 8'hB0,
    parameter logic [7:0] X_MAX         = 8'd159,
    parameter logic [6:0] Y_MAX         = 7'd119
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] X0,
    input  logic [7:0] X1,
    input  logic [6:0] Y0,
    input  logic [6:0] Y1,
`ifdef VGA_RECT_COLOUR_EN
    input  logic [7:0] COLOUR,
`endif
    input  logic       BUS_GNT,
    output logic       BUS_REQ,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       BUSY,
    output logic       DONE
);

    // -------------------------------------------------------------------------
    // Register map of the VGA peripheral as seen from this initiator
    // -------------------------------------------------------------------------
    localparam logic [7:0] COLOUR_ADDR = VGA_BASE_ADDR;
    localparam logic [7:0] X_ADDR      = VGA_BASE_ADDR + 8'd1;
    localparam logic [7:0] Y_ADDR      = VGA_BASE_ADDR + 8'd2;

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ROW  = 3'd3;
    localparam logic [2:0] ST_PIX  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;
`ifdef VGA_RECT_COLOUR_EN
    localparam logic [2:0] ST_COL  = 3'd2;
    // The colour write is the first bus write of every non-empty command.
    localparam logic [2:0] FIRST_PHASE = ST_COL;
`else
    localparam logic [2:0] FIRST_PHASE = ST_ROW;
`endif

    logic [2:0] state;

    // Latched, normalised and clamped rectangle bounds
    logic [7:0] xl;
    logic [7:0] xh;
    logic [6:0] yh;

    // Scan position
    logic [7:0] x;
    logic [6:0] y;

`ifdef VGA_RECT_COLOUR_EN
    logic [7:0] colour_q;
`endif

    // Command decode, evaluated on the raw inputs so it can be latched on accept
    logic [7:0] cmd_xl;
    logic [7:0] cmd_xh;
    logic [6:0] cmd_yl;
    logic [6:0] cmd_yh;
    logic       cmd_empty;

    // Write phase actually executed this cycle (REQ performs the first write)
    logic [2:0] phase;
    logic       x_last;
    logic       y_last;

    // Normalise the corners, clamp the upper bounds and detect empty commands
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cmd_xl    = X0;
        cmd_xh    = X1;
        cmd_yl    = Y0;
        cmd_yh    = Y1;
        cmd_empty = 1'b0;

        if (X1 < X0) begin
            cmd_xl = X1;
            cmd_xh = X0;
        end
        if (Y1 < Y0) begin
            cmd_yl = Y1;
            cmd_yh = Y0;
        end

        // Clamping the upper bounds means the scan counters never run past the
        // frame-buffer edge, so they cannot wrap around.
        if (cmd_xh > X_MAX) begin
            cmd_xh = X_MAX;
        end
        if (cmd_yh > Y_MAX) begin
            cmd_yh = Y_MAX;
        end

        // A lower bound outside the frame buffer leaves nothing to draw
        cmd_empty = (cmd_xl > X_MAX) || (cmd_yl > Y_MAX);
    end

    // Select the write phase and the end-of-row / end-of-rectangle conditions
    always_comb begin
        phase = state;
        if (state == ST_REQ) begin
            phase = FIRST_PHASE;
        end
        x_last = (x == xh);
        y_last = (y == yh);
    end

    // Control FSM, scan counters and registered bus outputs
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is assigned with non-blocking (<=) only.
        // Every flop samples the pre-edge values, whatever the statement order.
        if (RESET) begin
            // NOTE: the reset is synchronous. The design has no memory arrays,
            // so every register, datapath included, can reset cheaply and
            // simulation has no X state to chase.
            state    <= ST_IDLE;
            BUS_REQ  <= 1'b0;
            BUS_ADDR <= 8'h00;
            BUS_DATA <= 8'h00;
            BUS_WE   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            xl       <= 8'h00;
            xh       <= 8'h00;
            yh       <= 7'h00;
            x        <= 8'h00;
            y        <= 7'h00;
`ifdef VGA_RECT_COLOUR_EN
            colour_q <= 8'h00;
`endif
        end else begin
            // Bus idles at zero, and DONE is a single-cycle pulse, unless a
            // branch below overrides them.
            BUS_WE   <= 1'b0;
            BUS_ADDR <= 8'h00;
            BUS_DATA <= 8'h00;
            DONE     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (START) begin
                        xl   <= cmd_xl;
                        xh   <= cmd_xh;
                        yh   <= cmd_yh;
                        x    <= cmd_xl;
                        y    <= cmd_yl;
                        BUSY <= 1'b1;
`ifdef VGA_RECT_COLOUR_EN
                        colour_q <= COLOUR;
`endif
                        if (cmd_empty) begin
                            // Nothing to draw: skip the bus entirely
                            state <= ST_FIN;
                        end else begin
                            BUS_REQ <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end

`ifdef VGA_RECT_COLOUR_EN
                ST_COL,
`endif
                ST_REQ, ST_ROW, ST_PIX: begin
                    // Without a grant, hold position and keep requesting, so
                    // no write is skipped or repeated on regrant.
                    if (BUS_GNT) begin
                        case (phase)
`ifdef VGA_RECT_COLOUR_EN
                            ST_COL: begin
                                BUS_WE   <= 1'b1;
                                BUS_ADDR <= COLOUR_ADDR;
                                BUS_DATA <= colour_q;
                                state    <= ST_ROW;
                            end
`endif
                            ST_ROW: begin
                                BUS_WE   <= 1'b1;
                                BUS_ADDR <= Y_ADDR;
                                BUS_DATA <= {1'b0, y};
                                x        <= xl;
                                state    <= ST_PIX;
                            end
                            ST_PIX: begin
                                BUS_WE   <= 1'b1;
                                BUS_ADDR <= X_ADDR;
                                BUS_DATA <= x;
                                if (x_last) begin
                                    if (y_last) begin
                                        state <= ST_FIN;
                                    end else begin
                                        y     <= y + 7'd1;
                                        state <= ST_ROW;
                                    end
                                end else begin
                                    x <= x + 8'd1;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end

                ST_FIN: begin
                    // Drop the request together with the completion pulse
                    DONE    <= 1'b1;
                    BUSY    <= 1'b0;
                    BUS_REQ <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    // Unused encodings recover to a clean idle
                    BUSY    <= 1'b0;
                    BUS_REQ <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_rect_writer.md
# vga_rect_writer

Bus-initiator drawing engine for the VGA peripheral. Accepts a rectangle command (two corners), arbitrates for the shared 8-bit data bus, and issues one bus write per row (Y register) and one per pixel (X register) so the VGA block sets every frame-buffer pixel inside the rectangle. Sits beside the processor on the same bus, behind a simple request/grant handshake.

## Interface
- VGA_BASE_ADDR, 8'hB0, VGA colour register; X register = base+1, Y register = base+2
- X_MAX, 159, largest legal X (frame buffer 160 wide)
- Y_MAX, 119, largest legal Y (frame buffer 120 high)

- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle command strobe; sampled only in IDLE
- X0, X1  in  8  corner X coordinates
- Y0, Y1  in  7  corner Y coordinates
- COLOUR  in  8  rectangle colour (present only with VGA_RECT_COLOUR_EN)
- BUS_GNT  in  1  bus grant from arbiter
- BUS_REQ  out  1  bus request, registered
- BUS_ADDR  out  8  bus address, registered
- BUS_DATA  out  8  bus write data, registered
- BUS_WE  out  1  bus write enable, registered, one cycle per write
- BUSY  out  1  high from cycle after accepted START until DONE
- DONE  out  1  one-cycle completion pulse

## Operation
- Reset values: BUS_REQ=0, BUS_ADDR=8'h00, BUS_DATA=8'h00, BUS_WE=0, BUSY=0, DONE=0, state IDLE.
- When BUS_WE=0, BUS_ADDR and BUS_DATA are driven 8'h00 (bus idle value).
- START accepted in IDLE only; START in any other state ignored (no queueing).
- On accept: latch xl=min(X0,X1), xh=max(X0,X1), yl=min(Y0,Y1), yh=max(Y0,Y1); clamp xh to X_MAX, yh to Y_MAX; if xl>X_MAX or yl>Y_MAX the command is empty.
- States: IDLE -> REQ -> (COL) -> ROW -> PIX -> ... -> FIN -> IDLE.
  - REQ: BUS_REQ=1, wait for BUS_GNT=1. Empty command goes REQ-free: IDLE -> FIN directly.
  - COL (macro only): write VGA_BASE_ADDR <= COLOUR.
  - ROW: write VGA_BASE_ADDR+1... no: write Y register (base+2) <= {1'b0,y}; x <= xl.
  - PIX: write X register (base+1) <= x; if x==xh then (if y==yh -> FIN else y<=y+1, -> ROW) else x<=x+1.
  - FIN: DONE=1 one cycle, BUSY=0, BUS_REQ=0; -> IDLE.
- Grant loss: a write is issued only in a cycle where BUS_GNT is sampled high; if BUS_GNT low in ROW/COL/PIX, hold state and counters, BUS_WE=0, BUS_REQ stays 1; resume on regrant with no pixel skipped or repeated.
- Counters 8-bit X, 7-bit Y; comparisons against clamped bounds, so no wrap-around past X_MAX/Y_MAX.
- RESET mid-command: aborts at that edge, all outputs to reset values, no DONE.

## Timing
- START at edge 0 -> BUSY=1 and BUS_REQ=1 after edge 1.
- With BUS_GNT held high: first write (COL or ROW) visible after edge 2.
- Writes are back-to-back, one per cycle: count = H*(W+1) (+1 with macro), W=xh-xl+1, H=yh-yl+1.
- DONE asserted the cycle after last BUS_WE; BUS_REQ deasserted same cycle as DONE.
- Empty command: DONE after edge 2, no BUS_REQ, no writes.

## Configuration
- VGA_RECT_COLOUR_EN defined: COLOUR port exists; one write of COLOUR to VGA_BASE_ADDR precedes the first row write.
- Undefined: no COLOUR port, no COL state; colour register left untouched.

## Test plan
- Single pixel X0=X1=5, Y0=Y1=7, GNT tied 1 -> writes (B2,07),(B1,05); DONE next cycle; 2 writes total.
- 3x2 rect X0=10,X1=12,Y0=3,Y1=4 -> (B2,03),(B1,0A),(B1,0B),(B1,0C),(B2,04),(B1,0A),(B1,0B),(B1,0C); 8 consecutive BUS_WE cycles.
- Swapped corners X0=12,X1=10,Y0=4,Y1=3 -> identical sequence to previous case.
- Clamp X0=158,X1=200,Y0=119,Y1=119 -> (B2,77),(B1,9E),(B1,9F); X0=170,X1=180 -> DONE, zero writes.
- GNT low 3 cycles after second pixel write of 3x2 case -> BUS_WE=0 for those cycles, sequence resumes unchanged, total still 8 writes; START during BUSY ignored.
- RESET asserted mid-row -> next cycle all outputs 0, no DONE; with VGA_RECT_COLOUR_EN, COLOUR=8'h3C -> first write (B0,3C).
